// File: rtl/dag.sv
// Data address generator: four banks of eight I/M/L/B registers, circular-buffer
// address arithmetic, and a register read/write port. All results are registered.
module dag #(
    parameter int DMA_SIZE = 16,
    parameter int DMD_SIZE = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps_dg_en,
    input  logic [2:0]          ps_dg_iidx,
    input  logic [2:0]          ps_dg_midx,
    input  logic                ps_dg_pre,
    input  logic                ps_dg_wrt,
    input  logic                ps_dg_rd,
    input  logic [1:0]          ps_dg_sel,
    input  logic [2:0]          ps_dg_ridx,
    input  logic [DMD_SIZE-1:0] bc_dg_dt,
    output logic [DMA_SIZE-1:0] dg_dm_add,
    output logic [DMD_SIZE-1:0] dg_bc_dt
);
    localparam int SW = DMA_SIZE + 2;

    logic [DMA_SIZE-1:0] i_reg [8];
    logic [DMA_SIZE-1:0] m_reg [8];
    logic [DMA_SIZE-1:0] l_reg [8];
    logic [DMA_SIZE-1:0] b_reg [8];

    logic [DMA_SIZE-1:0] i_cur, m_cur, l_cur, b_cur;
    logic [DMA_SIZE-1:0] circ, wr_val, rd_val;
    logic [DMD_SIZE-1:0] rd_ext;
    logic signed [SW-1:0] sum, lim_lo, lim_hi;

    generate
        if (DMD_SIZE >= DMA_SIZE) begin : g_wr_trunc
            assign wr_val = bc_dg_dt[DMA_SIZE-1:0];
            assign rd_ext = {{(DMD_SIZE-DMA_SIZE){1'b0}}, rd_val};
        end else begin : g_wr_zext
            assign wr_val = {{(DMA_SIZE-DMD_SIZE){1'b0}}, bc_dg_dt};
            assign rd_ext = rd_val[DMD_SIZE-1:0];
        end
    endgenerate

    // Comparisons use a sign-extended sum so a negative step below B is seen as
    // below B; the address itself is produced in modulo-2^DMA_SIZE arithmetic.
    always_comb begin
        i_cur  = i_reg[ps_dg_iidx];
        m_cur  = m_reg[ps_dg_midx];
        l_cur  = l_reg[ps_dg_iidx];
        b_cur  = b_reg[ps_dg_iidx];
        sum    = $signed({2'b00, i_cur}) + $signed({{2{m_cur[DMA_SIZE-1]}}, m_cur});
        lim_lo = $signed({2'b00, b_cur});
        lim_hi = lim_lo + $signed({2'b00, l_cur});
        circ   = i_cur + m_cur;
        if (l_cur != '0) begin
            if (sum >= lim_hi) begin
                circ = i_cur + m_cur - l_cur;
            end else if (sum < lim_lo) begin
                circ = i_cur + m_cur + l_cur;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (ps_dg_sel)
            2'b00:   rd_val = i_reg[ps_dg_ridx];
            2'b01:   rd_val = m_reg[ps_dg_ridx];
            2'b10:   rd_val = l_reg[ps_dg_ridx];
            default: rd_val = b_reg[ps_dg_ridx];
        endcase
    end

    // The register write comes after the post-modify update so it wins on I[n].
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < 8; n++) begin
                i_reg[n] <= '0;
                m_reg[n] <= '0;
                l_reg[n] <= '0;
                b_reg[n] <= '0;
            end
            dg_dm_add <= '0;
            dg_bc_dt  <= '0;
        end else begin
            if (ps_dg_en) begin
                dg_dm_add <= ps_dg_pre ? circ : i_cur;
                if (!ps_dg_pre) begin
                    i_reg[ps_dg_iidx] <= circ;
                end
            end
            if (ps_dg_wrt) begin
                case (ps_dg_sel)
                    2'b00: i_reg[ps_dg_ridx] <= wr_val;
                    2'b01: m_reg[ps_dg_ridx] <= wr_val;
                    2'b10: l_reg[ps_dg_ridx] <= wr_val;
                    default: begin
                        b_reg[ps_dg_ridx] <= wr_val;
                        i_reg[ps_dg_ridx] <= wr_val;
                    end
                endcase
            end
            if (ps_dg_rd) begin
                dg_bc_dt <= rd_ext;
            end
        end
    end

endmodule
